fifo_burst_reader: RTL
======================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter DATA_W, default 8: width of FIFO read data and stream data.
REQ-002 Parameter BURST_LEN, default 8: beats per threshold burst, legal range 1..8.
REQ-003 clk  input  1: single clock, all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 fifo_data  input  DATA_W: show-ahead FIFO read data, valid whenever fifo_empty=0.
REQ-006 fifo_empty  input  1: FIFO empty status.
REQ-007 fifo_threshold  input  1: FIFO holds at least 8 words.
REQ-008 rd  output  1: FIFO pop strobe, combinational.
REQ-009 flush  input  1: single-cycle request to drain the FIFO completely.
REQ-010 m_valid  output  1: stream word valid.
REQ-011 m_data  output  DATA_W: stream word.
REQ-012 m_last  output  1: final beat of the current burst.
REQ-013 m_ready  input  1: downstream accepts the word when m_valid=1 and m_ready=1.
REQ-014 busy  output  1: FSM is not in IDLE.
REQ-015 burst_cnt  output  16: count of completed bursts, wraps 0xFFFF->0x0000.

Function
REQ-016 FSM states SHALL be IDLE, BURST, FLUSH.
REQ-017 IDLE SHALL go to FLUSH when flush_pend=1, otherwise to BURST when fifo_threshold=1; flush wins when both are set.
REQ-018 flush_pend SHALL set on a flush pulse in any state and clear on the FLUSH->IDLE transition.
REQ-019 The pop condition SHALL be rd = (state is BURST or FLUSH) & ~fifo_empty & (~m_valid | m_ready).
REQ-020 A pop SHALL load fifo_data into m_data and set m_valid on the next edge (1-cycle latency).
REQ-021 An accept without a same-cycle pop SHALL clear m_valid.
REQ-022 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-023 Sustained throughput SHALL be one word per cycle when m_ready=1.
REQ-024 In BURST, a beat counter SHALL count pops from 0; the pop at count BURST_LEN-1 SHALL carry m_last=1, return the FSM to IDLE and increment burst_cnt.
REQ-025 In FLUSH, every popped word SHALL carry m_last=1.
REQ-026 FLUSH SHALL return to IDLE in the first cycle in which fifo_empty=1 and no pop occurs; burst_cnt is unchanged by FLUSH.
REQ-027 A flush pulse during BURST SHALL NOT shorten the burst; it is serviced after return to IDLE.
REQ-028 A flush pulse while the FIFO is empty SHALL pass through FLUSH for exactly one cycle, with no pop.
REQ-029 rd SHALL never assert when fifo_empty=1, so no FIFO underflow is caused by this block.
REQ-030 The FSM SHALL re-enter BURST back-to-back, with one IDLE cycle, while fifo_threshold stays 1.

Reset
REQ-031 On rst=1 the block SHALL immediately and asynchronously force:
- state = IDLE; beat counter = 0; flush_pend = 0
- m_valid = 0, m_last = 0, m_data = 0
- burst_cnt = 0; busy = 0
REQ-032 rd SHALL be 0 while rst=1, and reset mid-burst SHALL discard the partial burst with no m_last emitted.

Structure
REQ-033 A shared package fifo_reader_pkg SHALL hold the state encoding and the default constants DATA_W=8 and BURST_LEN=8.
REQ-034 The output register (m_valid/m_data/m_last with its load/hold/clear logic) SHALL be one sub-module, stream_out_reg.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Burst at full rate: FIFO holds 8 words 0x10..0x17, threshold=1, m_ready=1 -> 8 consecutive beats 0x10..0x17, m_last only on 0x17, burst_cnt=1.
- Backpressure: m_ready toggles 1,0,0,1 during a burst -> no pop while m_valid=1 and m_ready=0, m_data held, no words lost or duplicated.
- Flush: FIFO holds 3 words 0xA0..0xA2, threshold=0, flush pulse -> 3 beats, each with m_last=1, then IDLE, burst_cnt unchanged.
- Flush mid-burst: flush pulse at beat 3, FIFO holds 11 words -> 8-beat burst completes, then FLUSH drains the remaining 3 words.
- Reset mid-burst: rst asserted at beat 4 -> m_valid=0 and busy=0 in the same cycle, burst_cnt=0, rd=0.
- Empty flush: flush pulse with fifo_empty=1 -> busy high for one cycle, rd never asserted, no m_valid.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO burst reader: state encoding and default sizing.
package fifo_reader_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_LEN = 8;
    // Wide enough for beat indices 0..7 (BURST_LEN is at most 8).
    localparam int BEAT_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry stream output register: loads on a pop, holds under backpressure,
// clears on an accept with no new load.
module stream_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= load_last;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads fixed-length bursts from a show-ahead FIFO once it reaches threshold,
// and drains it completely on request, presenting words on a valid/ready stream.
module fifo_burst_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic              fifo_threshold,
    output logic              rd,
    input  logic              flush,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic [15:0]       burst_cnt
);

    state_t            state_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic              flush_pend_reg;
    logic [15:0]       burst_cnt_reg;

    logic pop;
    logic beat_last;
    logic load_last;

    // Pop only when the output register is free or being emptied this cycle.
    assign pop       = !rst && (state_reg != ST_IDLE) && !fifo_empty && (!m_valid || m_ready);
    assign beat_last = (beat_reg == BEAT_W'(BURST_LEN - 1));
    assign load_last = (state_reg == ST_FLUSH) || ((state_reg == ST_BURST) && beat_last);

    assign rd        = pop;
    assign busy      = (state_reg != ST_IDLE);
    assign burst_cnt = burst_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= '0;
            flush_pend_reg <= 1'b0;
            burst_cnt_reg  <= '0;
        end else begin
            if (flush)
                flush_pend_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    beat_reg <= '0;
                    if (flush_pend_reg)
                        state_reg <= ST_FLUSH;
                    else if (fifo_threshold)
                        state_reg <= ST_BURST;
                end
                ST_BURST: begin
                    if (pop) begin
                        if (beat_last) begin
                            beat_reg      <= '0;
                            burst_cnt_reg <= burst_cnt_reg + 16'd1;
                            state_reg     <= ST_IDLE;
                        end else begin
                            beat_reg <= beat_reg + BEAT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // A new flush pulse arriving on the exit cycle keeps the request pending.
                    if (fifo_empty && !pop) begin
                        state_reg <= ST_IDLE;
                        if (!flush)
                            flush_pend_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    stream_out_reg #(
        .DATA_W(DATA_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (pop),
        .load_data (fifo_data),
        .load_last (load_last),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last)
    );

endmodule
